// File: rtl/frame_align_pkg.sv
// frame_align_pkg: shared definitions for the frame-alignment path and its monitors.
// Contents: state_t (3-bit FSM encoding), HDR_DEFAULT (expected header), cnt_w (counter width helper).
package frame_align_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HUNT   = 3'd1,
        SLIP   = 3'd2,
        SETTLE = 3'd3,
        LOCKED = 3'd4,
        FAIL   = 3'd5
    } state_t;

    localparam logic [1:0] HDR_DEFAULT = 2'b01;

    // Width able to hold v; never below one bit so a zero-valued limit still yields a legal vector.
    function automatic int cnt_w(input int v);
        return (v < 1) ? 1 : $clog2(v + 1);
    endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at its all-ones maximum.
// Ports: clk, RSTn (async active-low), inc (count up), clr (clear, wins over inc), count (value).
module sat_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         RSTn,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && count != {W{1'b1}})
            count <= count + 1'b1;
    end
endmodule

// File: rtl/frame_align_ctrl.sv
// frame_align_ctrl: bit-slip sequencer that hunts for a stable frame header, locks, and supervises lock.
// Ports: clk, RSTn (async active-low), enable, hdr_valid, hdr[1:0] in;
//        slip (one-cycle slip request), aligned, align_fail, slip_count[5:0],
//        relock_count[7:0], state[2:0] (debug) out. All outputs are registered.
module frame_align_ctrl
    import frame_align_pkg::*;
#(
    parameter logic [1:0] HDR_PATTERN = HDR_DEFAULT,
    parameter int         LOCK_GOAL   = 20,
    parameter int         UNLOCK_BAD  = 4,
    parameter int         SLIP_WAIT   = 16,
    parameter int         MAX_SLIPS   = 32
) (
    input  logic       clk,
    input  logic       RSTn,
    input  logic       enable,
    input  logic       hdr_valid,
    input  logic [1:0] hdr,
    output logic       slip,
    output logic       aligned,
    output logic       align_fail,
    output logic [5:0] slip_count,
    output logic [7:0] relock_count,
    output logic [2:0] state
);
    localparam int GW = cnt_w(LOCK_GOAL);
    localparam int BW = cnt_w(UNLOCK_BAD);
    localparam int WW = cnt_w(SLIP_WAIT - 1);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_GOAL - 1);
    localparam logic [BW-1:0] BAD_LAST  = BW'(UNLOCK_BAD - 1);
    localparam logic [WW-1:0] WAIT_LOAD = WW'(SLIP_WAIT - 1);

    state_t          st, st_nxt;
    logic [GW-1:0]   good_cnt, good_nxt;
    logic [BW-1:0]   bad_cnt, bad_nxt;
    logic [WW-1:0]   wait_cnt, wait_nxt;
    logic            slip_inc, slip_clr, relock_inc;

    wire good = hdr_valid && hdr == HDR_PATTERN;
    wire bad  = hdr_valid && hdr != HDR_PATTERN;

    always_comb begin
        st_nxt     = st;
        good_nxt   = good_cnt;
        bad_nxt    = bad_cnt;
        wait_nxt   = wait_cnt;
        slip_inc   = 1'b0;
        slip_clr   = 1'b0;
        relock_inc = 1'b0;
        case (st)
            IDLE: begin
                good_nxt = '0;
                bad_nxt  = '0;
                wait_nxt = '0;
                slip_clr = 1'b1;
                st_nxt   = enable ? HUNT : IDLE;
            end
            HUNT: begin
                if (good) begin
                    good_nxt = (good_cnt == GOOD_LAST) ? '0 : good_cnt + 1'b1;
                    st_nxt   = (good_cnt == GOOD_LAST) ? LOCKED : HUNT;
                end else if (bad) begin
                    good_nxt = '0;
                    st_nxt   = (32'(slip_count) < MAX_SLIPS) ? SLIP : FAIL;
                end
            end
            SLIP: begin
                slip_inc = 1'b1;
                wait_nxt = WAIT_LOAD;
                st_nxt   = SETTLE;
            end
            SETTLE: begin
                wait_nxt = (wait_cnt == '0) ? '0 : wait_cnt - 1'b1;
                st_nxt   = (wait_cnt == '0) ? HUNT : SETTLE;
            end
            LOCKED: begin
                if (good) begin
                    bad_nxt = '0;
                end else if (bad) begin
                    bad_nxt    = (bad_cnt == BAD_LAST) ? '0 : bad_cnt + 1'b1;
                    st_nxt     = (bad_cnt == BAD_LAST) ? HUNT : LOCKED;
                    slip_clr   = (bad_cnt == BAD_LAST);
                    relock_inc = (bad_cnt == BAD_LAST);
                end
            end
            FAIL: st_nxt = FAIL;
            default: st_nxt = IDLE;
        endcase
        // Dropping enable freezes everything for one edge; IDLE then does the clearing.
        if (!enable && st != IDLE) begin
            st_nxt     = IDLE;
            good_nxt   = good_cnt;
            bad_nxt    = bad_cnt;
            wait_nxt   = wait_cnt;
            slip_inc   = 1'b0;
            slip_clr   = 1'b0;
            relock_inc = 1'b0;
        end
    end

    // Flags are registered from the next state so they line up exactly with the state register.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            st         <= IDLE;
            good_cnt   <= '0;
            bad_cnt    <= '0;
            wait_cnt   <= '0;
            slip       <= 1'b0;
            aligned    <= 1'b0;
            align_fail <= 1'b0;
        end else begin
            st         <= st_nxt;
            good_cnt   <= good_nxt;
            bad_cnt    <= bad_nxt;
            wait_cnt   <= wait_nxt;
            slip       <= st_nxt == SLIP;
            aligned    <= st_nxt == LOCKED;
            align_fail <= st_nxt == FAIL;
        end
    end

    assign state = st;

    sat_counter #(.W(6)) u_slip_cnt (
        .clk   (clk),
        .RSTn  (RSTn),
        .inc   (slip_inc),
        .clr   (slip_clr),
        .count (slip_count)
    );

    sat_counter #(.W(8)) u_relock_cnt (
        .clk   (clk),
        .RSTn  (RSTn),
        .inc   (relock_inc),
        .clr   (1'b0),
        .count (relock_count)
    );
endmodule

// File: tb/tb_frame_align_ctrl.sv
// tb_frame_align_ctrl: self-checking bench for frame_align_ctrl (vector table, directed corners, random vs. model).
module tb_frame_align_ctrl;
    localparam int         LOCK_GOAL  = 20;
    localparam int         UNLOCK_BAD = 4;
    localparam int         SLIP_WAIT  = 16;
    localparam int         MAX_SLIPS  = 32;
    localparam logic [1:0] PAT        = 2'b01;
    localparam logic [1:0] BADH       = 2'b10;

    logic       clk = 1'b0;
    logic       RSTn = 1'b0;
    logic       enable = 1'b0;
    logic       hdr_valid = 1'b0;
    logic [1:0] hdr = 2'b00;
    logic       slip, aligned, align_fail;
    logic [5:0] slip_count;
    logic [7:0] relock_count;
    logic [2:0] state;

    always #5 clk = ~clk;

    frame_align_ctrl dut (
        .clk          (clk),
        .RSTn         (RSTn),
        .enable       (enable),
        .hdr_valid    (hdr_valid),
        .hdr          (hdr),
        .slip         (slip),
        .aligned      (aligned),
        .align_fail   (align_fail),
        .slip_count   (slip_count),
        .relock_count (relock_count),
        .state        (state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mode number plus plain integer streak counters; the settle
    // window is tracked as an absolute cycle number at which hunting resumes.
    int m_st, m_good, m_bad, m_slips, m_relocks, m_cyc, m_resume;

    task automatic model_reset();
        m_st = 0; m_good = 0; m_bad = 0; m_slips = 0; m_relocks = 0; m_cyc = 0; m_resume = 0;
    endtask

    task automatic model_step(input logic en, input logic hv, input logic [1:0] h);
        bit g, b;
        g = hv && h == PAT;
        b = hv && h != PAT;
        m_cyc++;
        if (!en && m_st != 0) begin
            m_st = 0;
            return;
        end
        case (m_st)
            0: begin
                m_good = 0; m_bad = 0; m_slips = 0;
                if (en) m_st = 1;
            end
            1: begin
                if (g) begin
                    m_good++;
                    if (m_good == LOCK_GOAL) begin m_st = 4; m_good = 0; end
                end else if (b) begin
                    m_good = 0;
                    m_st = (m_slips < MAX_SLIPS) ? 2 : 5;
                end
            end
            2: begin
                if (m_slips < 63) m_slips++;
                m_resume = m_cyc + SLIP_WAIT;
                m_st = 3;
            end
            3: if (m_cyc >= m_resume) m_st = 1;
            4: begin
                if (g) m_bad = 0;
                else if (b) begin
                    m_bad++;
                    if (m_bad == UNLOCK_BAD) begin
                        m_st = 1; m_bad = 0; m_slips = 0;
                        if (m_relocks < 255) m_relocks++;
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic check(input string name);
        logic [2:0] es;
        es = m_st[2:0];
        n_checks++;
        if (state !== es || slip !== (m_st == 2) || aligned !== (m_st == 4) || align_fail !== (m_st == 5) ||
            slip_count !== 6'(m_slips) || relock_count !== 8'(m_relocks)) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got st=%0d slip=%b al=%b fail=%b sc=%0d rc=%0d, expected st=%0d slip=%b al=%b fail=%b sc=%0d rc=%0d",
                     name, m_cyc, state, slip, aligned, align_fail, slip_count, relock_count,
                     es, m_st == 2, m_st == 4, m_st == 5, m_slips, m_relocks);
        end
    endtask

    task automatic expect_eq(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic drive_edge(input logic en, input logic hv, input logic [1:0] h);
        enable = en; hdr_valid = hv; hdr = h;
        @(posedge clk);
        model_step(en, hv, h);
        #1;
    endtask

    task automatic tick(input logic en, input logic hv, input logic [1:0] h);
        drive_edge(en, hv, h);
        check("model");
    endtask

    // Reset is asserted mid-cycle so the outputs must clear without waiting for an edge.
    task automatic do_reset();
        #2;
        RSTn = 1'b0;
        #1;
        model_reset();
        check("async_reset");
        enable = 1'b0;
        @(negedge clk);
        RSTn = 1'b1;
    endtask

    // Gearbox stand-in: header is correct only once `offset` slips have been applied.
    task automatic run_gearbox(input int start_offset, input int budget, output int pulses);
        int offset, last;
        offset = start_offset;
        last = -1;
        pulses = 0;
        for (int i = 0; i < budget && !aligned && !align_fail; i++) begin
            tick(1'b1, 1'b1, offset == 0 ? PAT : BADH);
            if (slip) begin
                pulses++;
                if (last >= 0) expect_eq("slip_spacing", i - last, SLIP_WAIT + 2);
                last = i;
                if (offset > 0) offset--;
            end
        end
        expect_eq("gearbox_finished", int'(aligned || align_fail), 1);
    endtask

    typedef struct {
        logic       en;
        logic       hv;
        logic [1:0] h;
        logic [2:0] st;
        logic       sl;
        logic       al;
        logic       fl;
        logic [5:0] sc;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int pulses, offset;
        logic en, hv;
        logic [1:0] h;
        tbl[0] = '{1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 6'd0};
        tbl[1] = '{1'b1, 1'b0, 2'b00, 3'd1, 1'b0, 1'b0, 1'b0, 6'd0};
        tbl[2] = '{1'b1, 1'b1, 2'b10, 3'd2, 1'b1, 1'b0, 1'b0, 6'd0};
        tbl[3] = '{1'b1, 1'b1, 2'b01, 3'd3, 1'b0, 1'b0, 1'b0, 6'd1};
        tbl[4] = '{1'b1, 1'b1, 2'b11, 3'd3, 1'b0, 1'b0, 1'b0, 6'd1};
        tbl[5] = '{1'b0, 1'b1, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 6'd1};
        tbl[6] = '{1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 6'd0};
        tbl[7] = '{1'b1, 1'b1, 2'b01, 3'd1, 1'b0, 1'b0, 1'b0, 6'd0};
        tbl[8] = '{1'b1, 1'b1, 2'b01, 3'd1, 1'b0, 1'b0, 1'b0, 6'd0};

        model_reset();
        #1;
        check("power_on_reset");
        @(negedge clk);
        RSTn = 1'b1;

        for (int i = 0; i < 9; i++) begin
            drive_edge(tbl[i].en, tbl[i].hv, tbl[i].h);
            n_checks++;
            if ({state, slip, aligned, align_fail, slip_count} !== {tbl[i].st, tbl[i].sl, tbl[i].al, tbl[i].fl, tbl[i].sc}) begin
                n_fail++;
                $display("FAIL vec%0d: got st=%0d slip=%b al=%b fail=%b sc=%0d, expected st=%0d slip=%b al=%b fail=%b sc=%0d",
                         i, state, slip, aligned, align_fail, slip_count,
                         tbl[i].st, tbl[i].sl, tbl[i].al, tbl[i].fl, tbl[i].sc);
            end
        end

        // Clean lock on the 20th good header.
        do_reset();
        tick(1'b1, 1'b0, 2'b00);
        for (int i = 1; i <= LOCK_GOAL; i++) begin
            tick(1'b1, 1'b1, PAT);
            if (i == LOCK_GOAL - 1) expect_eq("clean_not_yet", int'(aligned), 0);
        end
        expect_eq("clean_aligned", int'(aligned), 1);
        expect_eq("clean_state", int'(state), 4);
        expect_eq("clean_slips", int'(slip_count), 0);

        // Border three bits off: three slips, then lock.
        do_reset();
        tick(1'b1, 1'b0, 2'b00);
        run_gearbox(3, 2000, pulses);
        expect_eq("hunt_pulses", pulses, 3);
        expect_eq("hunt_slip_count", int'(slip_count), 3);
        expect_eq("hunt_state", int'(state), 4);

        // Lock loss: 3 bad + 1 good holds; 4 bad drops.
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, BADH);
        tick(1'b1, 1'b1, PAT);
        expect_eq("loss_still_locked", int'(state), 4);
        for (int i = 1; i <= UNLOCK_BAD; i++) begin
            tick(1'b1, 1'b1, BADH);
            if (i == UNLOCK_BAD - 1) expect_eq("loss_third_bad", int'(aligned), 1);
        end
        expect_eq("loss_aligned", int'(aligned), 0);
        expect_eq("loss_relock", int'(relock_count), 1);
        expect_eq("loss_slip_count", int'(slip_count), 0);

        // Relock, then drop enable while locked.
        for (int i = 0; i < LOCK_GOAL; i++) tick(1'b1, 1'b1, PAT);
        expect_eq("relocked", int'(aligned), 1);
        tick(1'b0, 1'b1, BADH);
        expect_eq("drop_en_state", int'(state), 0);
        expect_eq("drop_en_relock", int'(relock_count), 1);

        // Headers always bad: 32 slips then FAIL without a pulse.
        tick(1'b1, 1'b0, 2'b00);
        run_gearbox(1000, 3000, pulses);
        expect_eq("fail_pulses", pulses, MAX_SLIPS);
        expect_eq("fail_flag", int'(align_fail), 1);
        expect_eq("fail_no_slip", int'(slip), 0);
        expect_eq("fail_slip_count", int'(slip_count), MAX_SLIPS);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, BADH);
        expect_eq("fail_held", int'(state), 5);
        tick(1'b0, 1'b0, 2'b00);
        expect_eq("fail_exit_state", int'(state), 0);
        expect_eq("fail_exit_flag", int'(align_fail), 0);

        // Reset during SETTLE.
        tick(1'b1, 1'b0, 2'b00);
        tick(1'b1, 1'b1, BADH);
        tick(1'b1, 1'b0, 2'b00);
        tick(1'b1, 1'b0, 2'b00);
        expect_eq("settle_state", int'(state), 3);
        do_reset();
        expect_eq("reset_relock", int'(relock_count), 0);

        // Invalid-header gaps hold good_cnt.
        tick(1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, PAT);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 2'($urandom_range(0, 3)));
        for (int i = 0; i < LOCK_GOAL - 11; i++) tick(1'b1, 1'b1, PAT);
        expect_eq("gap_not_yet", int'(aligned), 0);
        tick(1'b1, 1'b1, PAT);
        expect_eq("gap_aligned", int'(aligned), 1);

        // Random traffic against the model.
        offset = $urandom_range(0, 5);
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 199) != 0);
            hv = ($urandom_range(0, 3) != 0);
            h  = (offset == 0) ? (($urandom_range(0, 29) == 0) ? 2'b11 : PAT) : 2'($urandom_range(0, 3));
            tick(en, hv, h);
            if (slip) offset = (offset > 0) ? offset - 1 : $urandom_range(0, 5);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/frame_align_ctrl.md
# frame_align_ctrl

Sequencer for the receive frame-alignment path. It watches the 2-bit frame header extracted at the current frame border and issues single-cycle bit-slip requests to the gearbox until the header pattern is stable. It then declares lock, supervises the lock, and reports statistics. It sits between the receive gearbox (recovered-clock domain) and the downstream data-enable and monitoring logic.

## Interface
- `HDR_PATTERN`, default 2'b01: expected header value.
- `LOCK_GOAL`, default 20: consecutive good headers required to lock.
- `UNLOCK_BAD`, default 4: consecutive bad headers in lock that drop lock.
- `SLIP_WAIT`, default 16: settle cycles after each slip, during which headers are ignored.
- `MAX_SLIPS`, default 32: slips allowed per hunt before declaring failure.
- `clk` in 1: receive clock (rx_clkout, 320 MHz).
- `RSTn` in 1: asynchronous, active-low reset.
- `enable` in 1: run alignment; low forces IDLE.
- `hdr_valid` in 1: `hdr` is valid this cycle.
- `hdr` in 2: header of the current frame.
- `slip` out 1: one-cycle request to move the frame border one bit later.
- `aligned` out 1: high in LOCKED; used as the data-output enable.
- `align_fail` out 1: high in FAIL.
- `slip_count` out 6: slips in the current hunt.
- `relock_count` out 8: lock-loss events, saturating at 255.
- `state` out 3: encoded FSM state, for debug.

## Operation
- States and encodings: IDLE=0, HUNT=1, SLIP=2, SETTLE=3, LOCKED=4, FAIL=5.
- A "good" header means `hdr_valid && hdr==HDR_PATTERN`. A "bad" header means `hdr_valid && hdr!=HDR_PATTERN`. Cycles with `hdr_valid` low change no counter and cause no transition.
- **IDLE**
  - good_cnt, bad_cnt, wait_cnt and slip_count are cleared.
  - When `enable` is high, go to HUNT.
- **HUNT**
  - A good header increments good_cnt. When good_cnt reaches LOCK_GOAL (i.e. on the LOCK_GOAL-th consecutive good header), go to LOCKED and clear good_cnt.
  - A bad header clears good_cnt.
    - If slip_count < MAX_SLIPS, go to SLIP.
    - Otherwise go to FAIL.
- **SLIP**
  - Lasts exactly one cycle; `slip`=1.
  - slip_count increments and saturates at 63.
  - Load wait_cnt=SLIP_WAIT-1, then go to SETTLE.
- **SETTLE**
  - Headers are ignored.
  - wait_cnt decrements; when it reaches 0, go to HUNT.
  - The total settle time is therefore SLIP_WAIT cycles.
- **LOCKED**
  - A good header clears bad_cnt.
  - A bad header increments bad_cnt. On the UNLOCK_BAD-th consecutive bad header:
    - go to HUNT;
    - relock_count increments (saturating);
    - bad_cnt and slip_count are cleared.
  - slip_count otherwise holds the number of slips taken to reach lock.
- **FAIL**
  - Held until `enable` is low.
  - No slips are issued.
- `enable` low has priority in every state: go to IDLE on the next edge. relock_count is not cleared by `enable`; it is cleared only by `RSTn`.
- Width rules:
  - good_cnt must hold LOCK_GOAL.
  - bad_cnt must hold UNLOCK_BAD.
  - wait_cnt must hold SLIP_WAIT-1.
  - Size each with $clog2(param+1).
  - Parameters are ≥1.

## Timing
- Reset values:
  - state=IDLE;
  - `slip`=0, `aligned`=0, `align_fail`=0;
  - slip_count=0, relock_count=0.
  - Reset takes effect immediately (asynchronous assertion). Deassertion is synchronous to `clk` via the external reset synchroniser.
- All outputs are registered, Moore-decoded from the state register plus counters. There is no combinational path from `hdr`/`hdr_valid` to any output.
- Latencies:
  - Bad header in HUNT at edge N gives `slip`=1 for the cycle after edge N.
  - The first header sampled again arrives SLIP_WAIT+1 cycles after the `slip` cycle.
  - The LOCK_GOAL-th good header at edge N gives `aligned`=1 from edge N.
  - The UNLOCK_BAD-th bad header at edge N gives `aligned`=0 from edge N.
- A good/bad header arriving together with `enable` falling is ignored; IDLE wins.
- A bad header arriving while slip_count==MAX_SLIPS goes to FAIL; no `slip` pulse is emitted.

## Structure
- A shared package `frame_align_pkg` holds:
  - the state enumeration and its 3-bit encoding;
  - the default header pattern constant;
  - the counter-width helper function.
  
  Downstream monitors use the same package.
- Sub-module `sat_counter` (width parameter, inc/clr, saturate-at-max) is instantiated for slip_count and relock_count.
- The FSM and the lock/settle counters stay in the top module.

## Test plan
- Clean lock: `enable`=1 with 20 consecutive good headers and no slip → `aligned` rises on the 20th header; `slip_count`=0; `state`=4.
- Hunt with slips: border offset 3 bits. The bench model shifts on each `slip`; headers are bad until 3 slips have occurred → exactly 3 `slip` pulses, each SLIP_WAIT=16 cycles apart plus hunt time; lock follows; `slip_count`=3.
- Lock loss:
  - In LOCKED, inject 3 bad headers then 1 good → still LOCKED.
  - Then inject 4 consecutive bad → `aligned` falls on the 4th; `relock_count`=1; `slip_count`=0.
- Failure: headers always bad → 32 `slip` pulses. The 33rd bad header gives `align_fail`=1 with no pulse. Dropping `enable` gives IDLE with `align_fail`=0.
- Gaps: `hdr_valid` low for 5 cycles mid-hunt → good_cnt is held, and lock occurs on the 20th good header regardless of gaps.
- Reset/enable mid-operation:
  - Assert `RSTn` low during SETTLE → all outputs return to their reset values immediately.
  - Drop `enable` in LOCKED → IDLE next edge, `relock_count` retained.
